// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A grant is held until the requester's last beat or MAX_BURST beats; the data path is purely combinational.
module fifo_write_arbiter #(
    parameter int BITS      = 32,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 8,
    localparam int GID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ-1:0][BITS-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]             req_last_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic                           fifo_wr_en_o,
    output logic [BITS-1:0]                fifo_wr_data_o,
    input  logic                           fifo_wr_full_i,
    output logic                           grant_active_o,
    output logic [GID_W-1:0]               grant_id_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [GID_W-1:0] grant_id_q, grant_id_d;
    logic [GID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic                          in_burst;
    logic                          accept;
    logic                          release_now;
    logic                          any_valid;
    logic [GID_W-1:0]              pick;
    logic [NUM_REQ-1:0]            hit;
    logic [NUM_REQ-1:0][GID_W-1:0] cand;

    // cand[k] is the requester k places after rr_ptr, wrapped modulo NUM_REQ
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_scan
        logic [GID_W:0] sum;
        assign sum       = {1'b0, rr_ptr_q} + (GID_W+1)'(gi);
        assign cand[gi]  = (sum >= (GID_W+1)'(NUM_REQ)) ? GID_W'(sum - (GID_W+1)'(NUM_REQ))
                                                        : GID_W'(sum);
        assign hit[gi]   = req_valid_i[cand[gi]];
    end

    always_comb begin
        pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                pick = cand[k];
            end
        end
    end

    assign any_valid   = |req_valid_i;
    assign in_burst    = (state_q == ST_BURST);
    assign accept      = in_burst & req_valid_i[grant_id_q] & ~fifo_wr_full_i;
    assign release_now = req_last_i[grant_id_q] | (beat_cnt_q == CNT_W'(MAX_BURST - 1));

    assign fifo_wr_en_o   = accept;
    assign fifo_wr_data_o = req_data_i[grant_id_q];
    assign grant_active_o = in_burst;
    assign grant_id_o     = grant_id_q;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign req_ready_o[gi] = in_burst & (grant_id_q == GID_W'(gi)) & ~fifo_wr_full_i;
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        if (state_q == ST_IDLE) begin
            if (any_valid) begin
                grant_id_d = pick;
                beat_cnt_d = '0;
                state_d    = ST_BURST;
            end
        end else if (accept) begin
            if (release_now) begin
                state_d    = ST_IDLE;
                beat_cnt_d = '0;
                rr_ptr_d   = (grant_id_q == GID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + GID_W'(1);
            end else begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (4 requesters, MAX_BURST=8) with hand-computed expectations.
module tb_fifo_write_arbiter;

    logic             clk;
    logic             rst;
    logic [3:0]       req_valid;
    logic [3:0][31:0] req_data;
    logic [3:0]       req_last;
    logic [3:0]       req_ready;
    logic             fifo_wr_en;
    logic [31:0]      fifo_wr_data;
    logic             fifo_wr_full;
    logic             grant_active;
    logic [1:0]       grant_id;

    int n_chk  = 0;
    int n_fail = 0;

    fifo_write_arbiter #(.BITS(32), .NUM_REQ(4), .MAX_BURST(8)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_last_i     (req_last),
        .req_ready_o    (req_ready),
        .fifo_wr_en_o   (fifo_wr_en),
        .fifo_wr_data_o (fifo_wr_data),
        .fifo_wr_full_i (fifo_wr_full),
        .grant_active_o (grant_active),
        .grant_id_o     (grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        int e;
        rst          = 1'b1;
        req_valid    = '0;
        req_data     = '0;
        req_last     = '0;
        fifo_wr_full = 1'b0;
        tick();
        tick();
        settle();
        chk("rst_grant_active", grant_active, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_ready", req_ready, 0);
        rst = 1'b0;

        // single requester, 3-beat packet
        req_valid[2] = 1'b1;
        req_data[2]  = 32'hA;
        settle();
        chk("idle_ready", req_ready, 0);
        chk("idle_wr_en", fifo_wr_en, 0);
        tick();
        settle();
        chk("t1_grant_active", grant_active, 1);
        chk("t1_grant_id", grant_id, 2);
        chk("t1_ready", req_ready, 4'b0100);
        chk("t1_wr_en_A", fifo_wr_en, 1);
        chk("t1_data_A", fifo_wr_data, 32'hA);
        tick();
        req_data[2] = 32'hB;
        settle();
        chk("t1_wr_en_B", fifo_wr_en, 1);
        chk("t1_data_B", fifo_wr_data, 32'hB);
        tick();
        req_data[2] = 32'hC;
        req_last[2] = 1'b1;
        settle();
        chk("t1_wr_en_C", fifo_wr_en, 1);
        chk("t1_data_C", fifo_wr_data, 32'hC);
        tick();
        req_valid = '0;
        req_last  = '0;
        settle();
        chk("t1_release", grant_active, 0);
        chk("t1_release_wr_en", fifo_wr_en, 0);

        // round-robin, all valid, 1-beat packets; rr_ptr is 3 here
        for (int i = 0; i < 4; i++) req_data[i] = 32'hD0 + 32'(i);
        req_valid = 4'hF;
        req_last  = 4'hF;
        settle();
        chk("rr_idle_wr_en", fifo_wr_en, 0);
        for (int g = 0; g < 8; g++) begin
            e = (3 + g) % 4;
            tick();
            settle();
            chk("rr_grant_active", grant_active, 1);
            chk("rr_grant_id", grant_id, e);
            chk("rr_wr_en", fifo_wr_en, 1);
            chk("rr_data", fifo_wr_data, 32'hD0 + 32'(e));
            tick();
            settle();
            chk("rr_bubble", grant_active, 0);
            chk("rr_bubble_wr_en", fifo_wr_en, 0);
        end
        req_valid = '0;
        req_last  = '0;

        // burst cap: requester 1 sends 20 beats, requester 3 cuts in; rr_ptr is 3
        req_valid[1] = 1'b1;
        req_data[1]  = 32'h100;
        tick();
        req_valid[3] = 1'b1;
        req_data[3]  = 32'h300;
        req_last[3]  = 1'b1;
        for (int b = 0; b < 20; b++) begin
            if (b == 8) begin
                settle();
                chk("cap_release_1", grant_active, 0);
                tick();
                settle();
                chk("cap_grant_3", grant_id, 3);
                chk("cap_data_3", fifo_wr_data, 32'h300);
                tick();
                req_valid[3] = 1'b0;
                req_last[3]  = 1'b0;
                settle();
                chk("cap_release_3", grant_active, 0);
                tick();
            end
            if (b == 16) begin
                settle();
                chk("cap_release_2", grant_active, 0);
                tick();
            end
            req_last[1] = (b == 19);
            settle();
            chk("cap_grant_id", grant_id, 1);
            chk("cap_wr_en", fifo_wr_en, 1);
            chk("cap_data", fifo_wr_data, 32'h100 + 32'(b));
            tick();
            req_data[1] = 32'h100 + 32'(b + 1);
        end
        req_valid = '0;
        req_last  = '0;
        settle();
        chk("cap_final_release", grant_active, 0);

        // full back-pressure for 5 cycles after 2 beats; cap at 8 proves beat_cnt held
        req_valid[0] = 1'b1;
        req_data[0]  = 32'h400;
        tick();
        for (int b = 0; b < 10; b++) begin
            if (b == 2) begin
                fifo_wr_full = 1'b1;
                for (int s = 0; s < 5; s++) begin
                    settle();
                    chk("full_ready", req_ready, 0);
                    chk("full_wr_en", fifo_wr_en, 0);
                    chk("full_grant_active", grant_active, 1);
                    tick();
                end
                fifo_wr_full = 1'b0;
            end
            if (b == 8) begin
                settle();
                chk("full_cap_release", grant_active, 0);
                tick();
            end
            req_last[0] = (b == 9);
            settle();
            chk("full_grant_id", grant_id, 0);
            chk("full_beat_wr_en", fifo_wr_en, 1);
            chk("full_beat_data", fifo_wr_data, 32'h400 + 32'(b));
            tick();
            req_data[0] = 32'h400 + 32'(b + 1);
        end
        req_valid = '0;
        req_last  = '0;
        settle();
        chk("full_final_release", grant_active, 0);

        // asynchronous reset mid-burst; rr_ptr is 1 so requester 2 is granted
        req_valid[2] = 1'b1;
        req_data[2]  = 32'h500;
        tick();
        for (int b = 0; b < 3; b++) begin
            settle();
            chk("ar_data", fifo_wr_data, 32'h500 + 32'(b));
            tick();
            req_data[2] = 32'h500 + 32'(b + 1);
        end
        settle();
        chk("ar_pre_wr_en", fifo_wr_en, 1);
        chk("ar_pre_grant_id", grant_id, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_ready", req_ready, 0);
        chk("ar_wr_en", fifo_wr_en, 0);
        chk("ar_grant_active", grant_active, 0);
        chk("ar_grant_id", grant_id, 0);
        tick();
        rst          = 1'b0;
        req_valid    = 4'b0101;
        req_data[0]  = 32'h600;
        req_last[0]  = 1'b0;
        req_last[2]  = 1'b1;
        settle();
        chk("ar_idle_after", grant_active, 0);
        tick();
        settle();
        chk("ar_first_grant", grant_id, 0);
        chk("ar_first_data", fifo_wr_data, 32'h600);

        // granted requester drops valid for 4 cycles; grant held, req_last[2] ignored
        tick();
        req_data[0]  = 32'h601;
        req_valid[0] = 1'b0;
        for (int s = 0; s < 4; s++) begin
            settle();
            chk("gap_grant_active", grant_active, 1);
            chk("gap_grant_id", grant_id, 0);
            chk("gap_wr_en", fifo_wr_en, 0);
            chk("gap_ready", req_ready, 4'b0001);
            tick();
        end
        req_valid[0] = 1'b1;
        req_last[0]  = 1'b1;
        settle();
        chk("gap_resume_wr_en", fifo_wr_en, 1);
        chk("gap_resume_data", fifo_wr_data, 32'h601);
        tick();
        req_valid[0] = 1'b0;
        req_last[0]  = 1'b0;
        settle();
        chk("gap_release", grant_active, 0);
        tick();
        settle();
        chk("gap_next_grant", grant_id, 2);
        chk("gap_next_data", fifo_wr_data, 32'h503);
        tick();
        req_valid = '0;
        req_last  = '0;
        settle();
        chk("gap_next_release", grant_active, 0);

        // wrap: grant on 3 releases, only requester 0 valid afterwards
        req_valid[3] = 1'b1;
        req_last[3]  = 1'b1;
        tick();
        settle();
        chk("wrap_grant_3", grant_id, 3);
        tick();
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        settle();
        chk("wrap_bubble", grant_active, 0);
        tick();
        settle();
        chk("wrap_grant_0", grant_id, 0);
        chk("wrap_active", grant_active, 1);
        tick();
        req_valid = '0;
        req_last  = '0;
        settle();
        chk("wrap_release", grant_active, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
